// File: rtl/input_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-channel stability counter, press/release pulses.
// Define INPUT_DEBOUNCER_TOGGLE_EN to add the per-channel btn_toggle output.
module input_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
    ,
    output logic [NUM_BUTTONS-1:0] btn_toggle
`endif
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The counter saturates at CNT_MAX; acceptance happens there, so it never wraps.
    function automatic logic cnt_done(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic [CNT_W-1:0] cnt;
        logic             level_r;
        logic             press_r;
        logic             release_r;

        // Synchronizer stage; s2 is the only raw-derived signal used past this point.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= btn_raw[i];
                s2 <= s1;
            end
        end

        // Stability counter and level/pulse registers: any s2 sample matching the
        // current level aborts the count, so only an unbroken run is accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt       <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                if (s2 == level_r) begin
                    cnt <= '0;
                end else if (cnt_done(cnt)) begin
                    cnt       <= '0;
                    level_r   <= s2;
                    press_r   <= s2;
                    release_r <= ~s2;
                end else begin
                    cnt <= cnt_inc(cnt);
                end
            end
        end

        assign btn_level[i]   = level_r;
        assign btn_press[i]   = press_r;
        assign btn_release[i] = release_r;

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        logic tog_r;

        // Toggle stage: flips on the edge after each press pulse.
        always_ff @(posedge clk) begin
            if (rst) begin
                tog_r <= 1'b0;
            end else begin
                tog_r <= tog_r ^ press_r;
            end
        end

        assign btn_toggle[i] = tog_r;
`endif
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus randomized button activity against a window-based reference model.
module tb_input_debouncer;

    localparam int NB = 2;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
    logic [NB-1:0] btn_toggle;
`endif

    int total = 0;
    int bad   = 0;

    input_debouncer #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle)
`else
        .btn_release (btn_release)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: raw reaches the debouncer two edges late; a channel
    // accepts the new level once its last DC synchronized samples all differ.
    logic [NB-1:0] dly[$];
    logic          win[NB][$];
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] m_press = '0;
    logic [NB-1:0] m_rel   = '0;
    logic [NB-1:0] m_tog   = '0;

    always @(posedge clk) begin
        logic [NB-1:0] s2_now;
        logic          all_diff;
        if (rst) begin
            dly.delete();
            dly.push_back('0);
            dly.push_back('0);
            for (int c = 0; c < NB; c++) win[c].delete();
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_tog   = '0;
        end else begin
            s2_now = dly.pop_front();
            dly.push_back(btn_raw);
            m_tog   = m_tog ^ m_press;
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < NB; c++) begin
                win[c].push_back(s2_now[c]);
                if (win[c].size() > DC) void'(win[c].pop_front());
                all_diff = (win[c].size() == DC);
                foreach (win[c][k]) if (win[c][k] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = s2_now[c];
                    if (s2_now[c]) m_press[c] = 1'b1;
                    else           m_rel[c]   = 1'b1;
                    win[c].delete();
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then compare everything against the model on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("level",   32'(btn_level),   32'(m_level));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("excl",    32'(btn_press & btn_release), 32'd0);
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        check("toggle",  32'(btn_toggle),  32'(m_tog));
`endif
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Reset held with both buttons pressed: all outputs stay low.
        rst     = 1'b1;
        btn_raw = 2'b11;
        for (int n = 0; n < 3; n++) begin
            step();
            check("rst_level", 32'(btn_level), 32'd0);
            check("rst_pulse", 32'(btn_press | btn_release), 32'd0);
`ifdef INPUT_DEBOUNCER_TOGGLE_EN
            check("rst_toggle", 32'(btn_toggle), 32'd0);
`endif
        end
        btn_raw = 2'b00;
        steps(2);

        // Channel 0 press: level and press pulse exactly at edge 2+DC.
        rst     = 1'b0;
        btn_raw = 2'b01;
        for (int n = 1; n <= 8; n++) begin
            step();
            check("p28_level", 32'(btn_level[0]), 32'(n >= 2 + DC));
            check("p28_press", 32'(btn_press[0]), 32'(n == 2 + DC));
        end
        btn_raw = 2'b00;
        steps(8);
        check("p28_reld", 32'(btn_level), 32'd0);

        // Channel 1 glitch of 3 clocks is rejected.
        btn_raw = 2'b10;
        steps(3);
        btn_raw = 2'b00;
        for (int n = 0; n < 8; n++) begin
            step();
            check("p29_level", 32'(btn_level[1]), 32'd0);
            check("p29_pulse", 32'(btn_press[1] | btn_release[1]), 32'd0);
        end

        // Simultaneous press and release on both channels.
        btn_raw = 2'b11;
        steps(2 + DC - 1);
        check("p30_pre", 32'(btn_press), 32'd0);
        step();
        check("p30_press", 32'(btn_press), 32'b11);
        steps(2);
        btn_raw = 2'b00;
        steps(2 + DC - 1);
        check("p30_pre_rel", 32'(btn_release), 32'd0);
        step();
        check("p30_release", 32'(btn_release), 32'b11);
        check("p30_level", 32'(btn_level), 32'd0);

        // Reset mid-count, button held through deassertion.
        btn_raw = 2'b01;
        steps(4);
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            step();
            check("p31_rst_press", 32'(btn_press), 32'd0);
        end
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            step();
            check("p31_press", 32'(btn_press[0]), 32'(n == 2 + DC));
        end

`ifdef INPUT_DEBOUNCER_TOGGLE_EN
        // Two separate full presses toggle channel 0 up then down.
        rst     = 1'b1;
        btn_raw = 2'b00;
        steps(2);
        rst     = 1'b0;
        btn_raw = 2'b01;
        steps(2 + DC + 1);
        check("p32_tog_up", 32'(btn_toggle[0]), 32'd1);
        btn_raw = 2'b00;
        steps(8);
        btn_raw = 2'b01;
        steps(2 + DC + 1);
        check("p32_tog_down", 32'(btn_toggle[0]), 32'd0);
`endif

        // Randomized activity: mixture of glitches, accepted changes and resets.
        for (int seg = 0; seg < 300; seg++) begin
            btn_raw = NB'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                steps($urandom_range(1, 2));
                rst = 1'b0;
            end
            steps($urandom_range(1, 2 * DC));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter NUM_BUTTONS, default 2: number of independent push-button channels, range 1 to 16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable clocks required to accept a new level, minimum 2.
REQ-003 clk  input  1  single clock for all state; the block has one clock and no other clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 btn_raw  input  NUM_BUTTONS  asynchronous raw push-button levels, 1 = pressed.
REQ-006 btn_level  output  NUM_BUTTONS  debounced, registered button level.
REQ-007 btn_press  output  NUM_BUTTONS  one-clock pulse on each accepted 0->1 transition of btn_level.
REQ-008 btn_release  output  NUM_BUTTONS  one-clock pulse on each accepted 1->0 transition of btn_level.
REQ-009 btn_toggle  output  NUM_BUTTONS  toggle state per channel; present only when INPUT_DEBOUNCER_TOGGLE_EN is defined.

Function
REQ-010 Each channel SHALL pass btn_raw through a two-flop synchronizer; sync output s2 SHALL be the only raw-derived signal used downstream.
REQ-011 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES), treated as unsigned and never wrapping.
REQ-012 If s2 equals btn_level, the counter SHALL clear to 0 on that edge.
REQ-013 If s2 differs from btn_level and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 If s2 differs from btn_level and counter == DEBOUNCE_CYCLES-1, btn_level SHALL load s2 and the counter SHALL clear on that edge.
REQ-015 Latency: a raw change held steady SHALL appear on btn_level exactly 2+DEBOUNCE_CYCLES rising edges after it is first sampled.
REQ-016 Any s2 excursion shorter than DEBOUNCE_CYCLES clocks SHALL produce no change on btn_level, btn_press or btn_release, and SHALL restart the count.
REQ-017 btn_press SHALL be registered, asserted for exactly the first cycle in which btn_level reads 1 after reading 0, and 0 otherwise.
REQ-018 btn_release SHALL be registered, asserted for exactly the first cycle in which btn_level reads 0 after reading 1, and 0 otherwise.
REQ-019 btn_press and btn_release SHALL never both be 1 on the same channel in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 The per-channel state is implicitly two states, STABLE (counter == 0) and COUNTING (counter > 0); the only exits from COUNTING are acceptance (REQ-014) or abort on s2 == btn_level (REQ-012).

Reset
REQ-022 While rst is 1 at a clock edge, the synchronizer flops, counters, btn_level, btn_press, btn_release and btn_toggle SHALL all clear to 0.
REQ-023 Reset asserted mid-count SHALL discard the count and SHALL produce no press or release pulse.
REQ-024 A button held pressed through reset deassertion SHALL be accepted as a new press 2+DEBOUNCE_CYCLES edges after the first non-reset edge.

Configuration
REQ-025 Macro INPUT_DEBOUNCER_TOGGLE_EN defined: btn_toggle SHALL exist and each bit SHALL invert on the edge following every cycle in which its btn_press bit is 1.
REQ-026 Macro INPUT_DEBOUNCER_TOGGLE_EN undefined: the btn_toggle port and its registers SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (NUM_BUTTONS=2, DEBOUNCE_CYCLES=4)
REQ-027 Hold rst=1 for 3 clocks with btn_raw=2'b11 -> btn_level, btn_press, btn_release and btn_toggle all 0 throughout.
REQ-028 btn_raw[0] 0->1 and held -> btn_level[0]=1 and btn_press[0]=1 for one cycle at edge 6; btn_press[0]=0 from edge 7 onward.
REQ-029 btn_raw[1] pulsed high for 3 clocks, then 0 -> btn_level[1], btn_press[1] and btn_release[1] stay 0.
REQ-030 btn_raw=2'b11 held, then 2'b00 held -> both btn_press bits pulse in the same cycle, then both btn_release bits pulse 6 edges after the release.
REQ-031 rst asserted 2 edges into a count -> no pulse; after rst deasserts with button still held, btn_press fires 6 edges later.
REQ-032 With INPUT_DEBOUNCER_TOGGLE_EN defined, two separate full presses on channel 0 -> btn_toggle[0] goes 0->1 after the first press and 1->0 after the second.
